// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the AD7324 conversion scheduler.
// Channel IDs follow the AD7324 input mux order used on the board.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } sched_state_e;

    localparam logic [1:0] CH_VOUT = 2'd0;
    localparam logic [1:0] CH_TEMP = 2'd1;
    localparam logic [1:0] CH_VIN  = 2'd2;
    localparam logic [1:0] CH_IOUT = 2'd3;

    localparam int CHID_HI  = 14;
    localparam int CHID_LO  = 13;
    localparam int DATA_MSB = 12;

endpackage

// File: rtl/adc_conv_scheduler_if.sv
// Link between the conversion scheduler and the spi_ad7324 front end.
// The scheduler is the master: it starts frames and consumes results.
interface adc_conv_scheduler_if;

    logic        SPI_HOLD;
    logic [1:0]  CH_SEL;
    logic        SPI_DONE;
    logic [15:0] DATA_READ;

    modport master (
        output SPI_HOLD,
        output CH_SEL,
        input  SPI_DONE,
        input  DATA_READ
    );

    modport slave (
        input  SPI_HOLD,
        input  CH_SEL,
        output SPI_DONE,
        output DATA_READ
    );

endinterface

// File: rtl/adc_conv_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter with an optional priority override.
// Purely combinational; the caller owns the rotating pointer.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic       prio_en_i,
    input  logic [1:0] prio_ch_i,
    output logic [3:0] gnt_o,
    output logic [1:0] win_o
);

    logic found;

    always_comb begin
        win_o = ptr_i;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req_i[ptr_i + 2'(i)]) begin
                win_o = ptr_i + 2'(i);
                found = 1'b1;
            end
        end
        if (prio_en_i && req_i[prio_ch_i]) begin
            win_o = prio_ch_i;
        end
        gnt_o = (|req_i) ? (4'b0001 << win_o) : 4'b0000;
    end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Schedules AD7324 conversions across the four measurement channels,
// checks the returned channel tag and emits offset-binary results.
module adc_conv_scheduler
    import adc_sched_pkg::*;
#(
    parameter int M       = 12,
    parameter int TIMEOUT = 63,
    parameter int GAP_CYC = 3
) (
    input  logic                 CLK20M,
    input  logic                 RSTn,
    input  logic                 EN,
    input  logic [3:0]           REQ,
    input  logic                 PRIO_EN,
    input  logic [1:0]           PRIO_CH,
    input  logic                 ERR_CLR,
    adc_conv_scheduler_if.master spi,
    output logic [3:0]           GNT,
    output logic [M:0]           RESULT,
    output logic [1:0]           RESULT_CH,
    output logic                 RESULT_VALID,
    output logic                 BUSY,
    output logic                 ERR_TIMEOUT,
    output logic                 ERR_CHID
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [M:0]    MSB_FLIP = {1'b1, {M{1'b0}}};

    sched_state_e st_q, st_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    ch_q, ch_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          hold_q, hold_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [M:0]    res_q, res_d;
    logic [1:0]    rch_q, rch_d;
    logic          rv_q, rv_d;
    logic          etmo_q, etmo_d;
    logic          echid_q, echid_d;
    logic          tmo_set, chid_set;

    logic [3:0] arb_gnt;
    logic [1:0] arb_win;
    logic [1:0] rx_ch;
    logic [M:0] rx_res;
    logic       unused_dr;

    rr_arbiter4 u_arb (
        .req_i     (REQ),
        .ptr_i     (ptr_q),
        .prio_en_i (PRIO_EN),
        .prio_ch_i (PRIO_CH),
        .gnt_o     (arb_gnt),
        .win_o     (arb_win)
    );

    // Sign-bit inversion turns the two's-complement field into offset binary
    assign rx_ch     = spi.DATA_READ[CHID_HI:CHID_LO];
    assign rx_res    = spi.DATA_READ[DATA_MSB -: M+1] ^ MSB_FLIP;
    assign unused_dr = ^spi.DATA_READ;

    always_comb begin
        st_d     = st_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        gnt_d    = gnt_q;
        hold_d   = 1'b0;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        res_d    = res_q;
        rch_d    = rch_q;
        rv_d     = 1'b0;
        tmo_set  = 1'b0;
        chid_set = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (EN && |REQ) st_d = S_ARB;
            end
            S_ARB: begin
                if (|REQ) begin
                    st_d   = S_START;
                    ch_d   = arb_win;
                    gnt_d  = arb_gnt;
                    ptr_d  = arb_win + 2'd1;
                    hold_d = 1'b1;
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_START: begin
                st_d  = S_WAIT;
                cnt_d = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Result is registered on the done edge so the strobe
                // lands in CAPTURE, one cycle after SPI_DONE
                if (spi.SPI_DONE) begin
                    st_d = S_CAPTURE;
                    if (rx_ch == ch_q) begin
                        res_d = rx_res;
                        rch_d = ch_q;
                        rv_d  = 1'b1;
                    end else begin
                        chid_set = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    st_d    = S_GAP;
                    gnt_d   = '0;
                    gap_d   = '0;
                    tmo_set = 1'b1;
                end
            end
            S_CAPTURE: begin
                st_d  = S_GAP;
                gnt_d = '0;
                gap_d = '0;
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
        etmo_d  = (etmo_q & ~ERR_CLR) | tmo_set;
        echid_d = (echid_q & ~ERR_CLR) | chid_set;
    end

    always_ff @(posedge CLK20M or negedge RSTn) begin
        if (!RSTn) begin
            st_q    <= S_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            res_q   <= '0;
            rch_q   <= '0;
            rv_q    <= 1'b0;
            etmo_q  <= 1'b0;
            echid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            res_q   <= res_d;
            rch_q   <= rch_d;
            rv_q    <= rv_d;
            etmo_q  <= etmo_d;
            echid_q <= echid_d;
        end
    end

    assign spi.SPI_HOLD = hold_q;
    assign spi.CH_SEL   = ch_q;
    assign GNT          = gnt_q;
    assign RESULT       = res_q;
    assign RESULT_CH    = rch_q;
    assign RESULT_VALID = rv_q;
    assign BUSY         = (st_q != S_IDLE);
    assign ERR_TIMEOUT  = etmo_q;
    assign ERR_CHID     = echid_q;

endmodule
